// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache.
// State encoding, address-field width functions and the big-endian byte-merge used on write hits.
package dcache_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WRITEBACK  = 3'd1;
    localparam logic [2:0] ST_REFILL     = 3'd2;
    localparam logic [2:0] ST_FLUSH_SCAN = 3'd3;
    localparam logic [2:0] ST_FLUSH_WB   = 3'd4;
    localparam logic [2:0] ST_FLUSH_DONE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_WRITEBACK  = ST_WRITEBACK,
        S_REFILL     = ST_REFILL,
        S_FLUSH_SCAN = ST_FLUSH_SCAN,
        S_FLUSH_WB   = ST_FLUSH_WB,
        S_FLUSH_DONE = ST_FLUSH_DONE
    } state_t;

    function automatic int ofs_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int num_sets, input int line_words);
        return addr_w - idx_w(num_sets) - ofs_w(line_words);
    endfunction

    // Byte at offset k lives in bits [31-8k -: 8]; the N low bytes of wdata land at
    // offsets offset..offset+N-1, most significant source byte first.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  offset,
                                                input logic [1:0]  size);
        logic [31:0] res;
        int n;
        int pos;
        res = old_word;
        n = (size == 2'd0) ? 4 : int'(size);
        for (int j = 0; j < 4; j++) begin
            pos = int'(offset) + j;
            if (j < n && pos < 4) begin
                res[31 - 8*pos -: 8] = wdata[8*(n-1-j) +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid/dirty/tag storage for the direct-mapped cache: one set looked up and updated per cycle.
// Valid and dirty bits clear on reset; tags are not reset since a cleared valid bit masks them.
module dcache_tag_array
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 64,
    parameter int TAG_W    = 21
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(NUM_SETS)-1:0] idx,
    output logic                        line_valid,
    output logic                        line_dirty,
    output logic [TAG_W-1:0]            line_tag,
    input  logic                        install,
    input  logic [TAG_W-1:0]            new_tag,
    input  logic                        set_dirty,
    input  logic                        clear_dirty,
    input  logic                        invalidate
);

    logic [NUM_SETS-1:0] valid_reg;
    logic [NUM_SETS-1:0] dirty_reg;
    logic [TAG_W-1:0]    tag_mem [NUM_SETS];

    assign line_valid = valid_reg[idx];
    assign line_dirty = dirty_reg[idx];
    assign line_tag   = tag_mem[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (install) begin
            valid_reg[idx] <= 1'b1;
            dirty_reg[idx] <= 1'b0;
        end else if (invalidate) begin
            valid_reg[idx] <= 1'b0;
            dirty_reg[idx] <= 1'b0;
        end else if (set_dirty) begin
            dirty_reg[idx] <= 1'b1;
        end else if (clear_dirty) begin
            dirty_reg[idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            tag_mem[idx] <= new_tag;
        end
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped write-back, write-allocate data cache with whole-cache flush.
// Optional statistics counters are built when DCACHE_STATS_EN is defined; otherwise they read 0.
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int NUM_SETS   = 64,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [ADDR_W-1:0]        data_address_2DC,
    input  logic                     read_2DC,
    input  logic                     write_2DC,
    input  logic [31:0]              data_write_2DC,
    input  logic [1:0]               data_write_size_2DC,
    input  logic                     flush_2DC,
    output logic [31:0]              data_read_fDC,
    output logic                     data_valid_fDC,
    output logic                     flush_done_fDC,
    output logic [ADDR_W-1:0]        data_address_2DM,
    output logic                     dBlkRead,
    output logic                     dBlkWrite,
    input  logic [32*LINE_WORDS-1:0] block_read_fDM,
    input  logic                     block_read_fDM_valid,
    output logic [32*LINE_WORDS-1:0] block_write_2DM,
    input  logic                     block_write_fDM_valid,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count,
    output logic [31:0]              wb_count
);

    localparam int OFS       = ofs_w(LINE_WORDS);
    localparam int IDX       = idx_w(NUM_SETS);
    localparam int TAG       = tag_w(ADDR_W, NUM_SETS, LINE_WORDS);
    localparam int WSEL_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int LINE_BITS = 32 * LINE_WORDS;

    state_t state_reg, state_next;
    logic [IDX-1:0] scan_reg, scan_next;

    logic [LINE_BITS-1:0] data_array [NUM_SETS];

    logic [IDX-1:0]       req_idx;
    logic [TAG-1:0]       req_tag;
    logic [WSEL_W-1:0]    req_word;
    logic [IDX-1:0]       lookup_idx;
    logic                 flushing;
    logic                 line_valid, line_dirty;
    logic [TAG-1:0]       line_tag;
    logic [LINE_BITS-1:0] cur_line;
    logic [31:0]          cur_word;
    logic                 req_active, hit;
    logic [ADDR_W-1:0]    victim_addr, req_line_addr;

    logic                 install, set_dirty, clear_dirty, invalidate;
    logic                 line_we;
    logic [LINE_BITS-1:0] line_wdata;
    logic                 hit_evt, miss_evt, wb_evt;

    assign req_idx    = data_address_2DC[OFS +: IDX];
    assign req_tag    = data_address_2DC[ADDR_W-1 -: TAG];
    assign req_word   = (LINE_WORDS > 1) ? data_address_2DC[2 +: WSEL_W] : '0;
    assign flushing   = (state_reg == S_FLUSH_SCAN) || (state_reg == S_FLUSH_WB);
    // Every update targets the set being looked up, so one index serves both paths.
    assign lookup_idx = flushing ? scan_reg : req_idx;

    assign cur_line      = data_array[lookup_idx];
    assign cur_word      = cur_line[32*req_word +: 32];
    assign req_active    = read_2DC | write_2DC;
    assign hit           = line_valid && (line_tag == req_tag);
    assign victim_addr   = {line_tag, lookup_idx, {OFS{1'b0}}};
    assign req_line_addr = {data_address_2DC[ADDR_W-1:OFS], {OFS{1'b0}}};

    dcache_tag_array #(
        .NUM_SETS (NUM_SETS),
        .TAG_W    (TAG)
    ) u_tags (
        .clk         (CLK),
        .rst_n       (RESET),
        .idx         (lookup_idx),
        .line_valid  (line_valid),
        .line_dirty  (line_dirty),
        .line_tag    (line_tag),
        .install     (install),
        .new_tag     (req_tag),
        .set_dirty   (set_dirty),
        .clear_dirty (clear_dirty),
        .invalidate  (invalidate)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= S_IDLE;
            scan_reg  <= '0;
        end else begin
            state_reg <= state_next;
            scan_reg  <= scan_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (line_we) begin
            data_array[lookup_idx] <= line_wdata;
        end
    end

    always_comb begin
        state_next       = state_reg;
        scan_next        = scan_reg;
        data_read_fDC    = '0;
        data_valid_fDC   = 1'b0;
        flush_done_fDC   = 1'b0;
        data_address_2DM = '0;
        dBlkRead         = 1'b0;
        dBlkWrite        = 1'b0;
        block_write_2DM  = '0;
        install          = 1'b0;
        set_dirty        = 1'b0;
        clear_dirty      = 1'b0;
        invalidate       = 1'b0;
        line_we          = 1'b0;
        line_wdata       = cur_line;
        hit_evt          = 1'b0;
        miss_evt         = 1'b0;
        wb_evt           = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                if (flush_2DC) begin
                    state_next = S_FLUSH_SCAN;
                    scan_next  = '0;
                end else if (req_active) begin
                    if (hit) begin
                        data_valid_fDC = 1'b1;
                        hit_evt        = 1'b1;
                        if (read_2DC) begin
                            data_read_fDC = cur_word;
                        end else begin
                            line_we   = 1'b1;
                            set_dirty = 1'b1;
                            line_wdata[32*req_word +: 32] = merge_bytes(cur_word, data_write_2DC,
                                                                        data_address_2DC[1:0],
                                                                        data_write_size_2DC);
                        end
                    end else begin
                        miss_evt   = 1'b1;
                        state_next = (line_valid && line_dirty) ? S_WRITEBACK : S_REFILL;
                    end
                end
            end
            S_WRITEBACK: begin
                dBlkWrite        = 1'b1;
                data_address_2DM = victim_addr;
                block_write_2DM  = cur_line;
                if (block_write_fDM_valid) begin
                    clear_dirty = 1'b1;
                    wb_evt      = 1'b1;
                    state_next  = S_REFILL;
                end
            end
            S_REFILL: begin
                dBlkRead         = 1'b1;
                data_address_2DM = req_line_addr;
                if (block_read_fDM_valid) begin
                    install    = 1'b1;
                    line_we    = 1'b1;
                    line_wdata = block_read_fDM;
                    state_next = S_IDLE;
                end
            end
            S_FLUSH_SCAN: begin
                if (line_valid && line_dirty) begin
                    state_next = S_FLUSH_WB;
                end else begin
                    invalidate = 1'b1;
                    if (scan_reg == IDX'(NUM_SETS - 1)) state_next = S_FLUSH_DONE;
                    else                                 scan_next  = scan_reg + 1'b1;
                end
            end
            S_FLUSH_WB: begin
                dBlkWrite        = 1'b1;
                data_address_2DM = victim_addr;
                block_write_2DM  = cur_line;
                if (block_write_fDM_valid) begin
                    invalidate = 1'b1;
                    wb_evt     = 1'b1;
                    if (scan_reg == IDX'(NUM_SETS - 1)) begin
                        state_next = S_FLUSH_DONE;
                    end else begin
                        scan_next  = scan_reg + 1'b1;
                        state_next = S_FLUSH_SCAN;
                    end
                end
            end
            S_FLUSH_DONE: begin
                flush_done_fDC = 1'b1;
                state_next     = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_reg, miss_count_reg, wb_count_reg;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
            wb_count_reg   <= '0;
        end else begin
            if (hit_evt)  hit_count_reg  <= hit_count_reg + 32'd1;
            if (miss_evt) miss_count_reg <= miss_count_reg + 32'd1;
            if (wb_evt)   wb_count_reg   <= wb_count_reg + 32'd1;
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
    assign wb_count   = wb_count_reg;
`else
    logic unused_stats;
    assign unused_stats = ^{hit_evt, miss_evt, wb_evt};
    assign hit_count    = '0;
    assign miss_count   = '0;
    assign wb_count     = '0;
`endif

endmodule
